// File: rtl/cache_pkg.sv
// Shared state encoding, geometry constants and tag helper for the
// direct-mapped write-through cache controller.
package cache_pkg;

  localparam int CACHE_DATA_W  = 13;
  localparam int CACHE_ADDR_W  = 13;
  localparam int CACHE_INDEX_W = 3;
  localparam int CACHE_CNT_W   = 8;

  localparam int TAG_W = CACHE_ADDR_W - CACHE_INDEX_W + 1;
  localparam int LINES = 2 ** CACHE_INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    MISS_RD,
    WR_THRU,
    DONE
  } cache_state_e;

  // The instruction flag sits above the address bits so that fetches and
  // data accesses to the same address never alias in the tag compare.
  function automatic logic [TAG_W-1:0] compose_tag(
    input logic                    instr,
    input logic [CACHE_ADDR_W-1:0] addr
  );
    return {instr, addr[CACHE_ADDR_W-1:CACHE_INDEX_W]};
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for the cache lines: one combinational read port,
// one write port, single-cycle flush and async clear of the valid bits.
module cache_line_array #(
  parameter int DATA_W  = 13,
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 11
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [DATA_W-1:0]  rd_data_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  input  logic               flush_i
);

  localparam int NLINES = 2 ** INDEX_W;

  logic [NLINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [DATA_W-1:0] data_q [NLINES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/dmap_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller sitting
// between the load/store path and Main_Memory, with hit/miss counters.
module dmap_cache_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_W  = CACHE_DATA_W,
  parameter int ADDR_W  = CACHE_ADDR_W,
  parameter int INDEX_W = CACHE_INDEX_W,
  parameter int CNT_W   = CACHE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic              cpu_instruction,
  input  logic              flush,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut,
  output logic              mem_write,
  output logic              mem_read,
  output logic              mem_instruction,
  input  logic              mem_done,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  cache_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              instr_q, instr_d;
  logic              flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [DATA_W-1:0]  line_data;
  logic               lookup_hit;
  logic               arr_we;
  logic [INDEX_W-1:0] arr_idx;
  logic [TAG_W-1:0]   arr_tag;
  logic [DATA_W-1:0]  arr_data;
  logic               arr_flush;

  cache_line_array #(
    .DATA_W (DATA_W),
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_lines (
    .clk_i     (clk),
    .rst_ni    (reset),
    .rd_index_i(cpu_addr[INDEX_W-1:0]),
    .rd_valid_o(line_valid),
    .rd_tag_o  (line_tag),
    .rd_data_o (line_data),
    .wr_en_i   (arr_we),
    .wr_index_i(arr_idx),
    .wr_tag_i  (arr_tag),
    .wr_data_i (arr_data),
    .flush_i   (arr_flush)
  );

  assign lookup_hit = line_valid && (line_tag == compose_tag(cpu_instruction, cpu_addr));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    instr_d      = instr_q;
    flush_pend_d = flush_pend_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    arr_we       = 1'b0;
    arr_idx      = cpu_addr[INDEX_W-1:0];
    arr_tag      = compose_tag(cpu_instruction, cpu_addr);
    arr_data     = cpu_wdata;
    arr_flush    = 1'b0;

    if (flush && state_q != IDLE) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // A deferred flush takes this whole cycle, so any request waits one more edge.
        if (flush_pend_q) begin
          arr_flush    = 1'b1;
          flush_pend_d = 1'b0;
        end else if (cpu_write || cpu_read) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          instr_d = cpu_instruction;
          if (flush) begin
            flush_pend_d = 1'b1;
          end
          if (cpu_write) begin
            arr_we  = lookup_hit;
            state_d = WR_THRU;
          end else if (lookup_hit) begin
            rdata_d = line_data;
            hit_d   = (hit_q == '1) ? hit_q : hit_q + 1'b1;
            state_d = DONE;
          end else begin
            miss_d  = (miss_q == '1) ? miss_q : miss_q + 1'b1;
            state_d = MISS_RD;
          end
        end else if (flush) begin
          arr_flush = 1'b1;
        end
      end
      MISS_RD: begin
        if (mem_done) begin
          arr_we   = 1'b1;
          arr_idx  = addr_q[INDEX_W-1:0];
          arr_tag  = compose_tag(instr_q, addr_q);
          arr_data = mem_dataOut;
          rdata_d  = mem_dataOut;
          state_d  = DONE;
        end
      end
      WR_THRU: begin
        if (mem_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      instr_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      instr_q      <= instr_d;
      flush_pend_q <= flush_pend_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  // Memory strobes decode straight from state so a reset drops them at once.
  assign mem_read        = (state_q == MISS_RD);
  assign mem_write       = (state_q == WR_THRU);
  assign cpu_done        = (state_q == DONE);
  assign mem_address     = addr_q;
  assign mem_dataIn      = wdata_q;
  assign mem_instruction = instr_q;
  assign cpu_rdata       = rdata_q;
  assign hit_count       = hit_q;
  assign miss_count      = miss_q;

endmodule

// File: tb/tb_dmap_cache_ctrl.sv
// Self-checking bench for dmap_cache_ctrl: a behavioural Main_Memory with random
// latency plus an abstract cache-content model predicting hits, data and counters.
module tb_dmap_cache_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [12:0] cpu_addr;
   logic [12:0] cpu_wdata;
   logic        cpu_read;
   logic        cpu_write;
   logic        cpu_instruction;
   logic        flush;
   logic [12:0] cpu_rdata;
   logic        cpu_done;
   logic [12:0] mem_address;
   logic [12:0] mem_dataIn;
   logic [12:0] mem_dataOut;
   logic        mem_write;
   logic        mem_read;
   logic        mem_instruction;
   logic        mem_done;
   logic [7:0]  hit_count;
   logic [7:0]  miss_count;

   int testsRun = 0;
   int testsFailed = 0;

   logic [12:0] dmem [0:8191];
   logic [12:0] imem [0:8191];
   int          memReads = 0;
   int          memWrites = 0;
   logic [12:0] lastWrAddr;
   logic [12:0] lastWrData;
   logic        lastRdInstr;
   int          forceLat = -1;
   int          respLat = 0;
   int          respCnt = 0;
   bit          respBusy = 1'b0;
   logic [12:0] respAddr;

   bit          modelValid [8];
   logic [13:0] modelKey [8];
   int          expHits = 0;
   int          expMisses = 0;

   dmap_cache_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_read       (cpu_read),
      .cpu_write      (cpu_write),
      .cpu_instruction(cpu_instruction),
      .flush          (flush),
      .cpu_rdata      (cpu_rdata),
      .cpu_done       (cpu_done),
      .mem_address    (mem_address),
      .mem_dataIn     (mem_dataIn),
      .mem_dataOut    (mem_dataOut),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .mem_instruction(mem_instruction),
      .mem_done       (mem_done),
      .hit_count      (hit_count),
      .miss_count     (miss_count)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Main_Memory stand-in: answers each read/write after a random number of
   // cycles, checks the strobes are exclusive and the address stays put.
   initial begin
      mem_done = 1'b0;
      mem_dataOut = '0;
      forever begin
         @(negedge clk);
         mem_done = 1'b0;
         if (!reset) begin
            respBusy = 1'b0;
            respCnt = 0;
         end else if (mem_read || mem_write) begin
            testsRun++;
            if (mem_read && mem_write) begin
               testsFailed++;
               $display("[TB] FAIL strobe_exclusive: got read=%b write=%b, required not both", mem_read, mem_write);
            end
            if (!respBusy) begin
               respBusy = 1'b1;
               respCnt = 0;
               respAddr = mem_address;
               respLat = (forceLat >= 0) ? forceLat : int'($urandom_range(0, 3));
            end else begin
               testsRun++;
               if (mem_address !== respAddr) begin
                  testsFailed++;
                  $display("[TB] FAIL addr_stable: got %h required %h", mem_address, respAddr);
               end
            end
            if (respCnt == respLat) begin
               mem_done = 1'b1;
               respBusy = 1'b0;
               if (mem_read) begin
                  mem_dataOut = mem_instruction ? imem[mem_address] : dmem[mem_address];
                  lastRdInstr = mem_instruction;
                  memReads++;
               end else begin
                  dmem[mem_address] = mem_dataIn;
                  lastWrAddr = mem_address;
                  lastWrData = mem_dataIn;
                  memWrites++;
               end
            end else begin
               respCnt++;
            end
         end
      end
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Clears the abstract cache model, as a flush or reset does.
   task automatic modelInvalidate();
      for (int i = 0; i < 8; i++) modelValid[i] = 1'b0;
   endtask

   // Runs one request from an IDLE negedge through cpu_done and one idle cycle,
   // checking memory traffic, data, latency, counters and the done pulse width.
   task automatic applyStimulus(input logic [12:0] a, input logic [12:0] wd, input bit rd,
                                input bit wr, input bit ins, input bit flushMid,
                                input bit checkLat, input string name);
      int          rdBefore;
      int          wrBefore;
      int          cycles;
      int          expCycles;
      bit          seen;
      bit          isHit;
      bit          isRead;
      logic [12:0] expData;
      rdBefore = memReads;
      wrBefore = memWrites;
      isRead = rd && !wr;
      isHit = isRead && modelValid[a[2:0]] && (modelKey[a[2:0]] == {ins, a});
      expData = ins ? imem[a] : dmem[a];
      cpu_addr = a;
      cpu_wdata = wd;
      cpu_read = rd;
      cpu_write = wr;
      cpu_instruction = ins;
      cycles = 0;
      seen = 1'b0;
      while (!seen && cycles < 60) begin
         @(negedge clk);
         cycles++;
         if (flushMid) flush = (cycles == 1);
         if (cpu_done === 1'b1) seen = 1'b1;
      end
      flush = 1'b0;
      testsRun++;
      if (!seen) begin
         testsFailed++;
         $display("[TB] FAIL %s done_timeout: got no cpu_done required cpu_done within 60 cycles", name);
      end
      if (isRead) begin
         testsRun++;
         if (memReads !== rdBefore + (isHit ? 0 : 1)) begin
            testsFailed++;
            $display("[TB] FAIL %s hit_miss_path: got %0d mem reads required %0d", name, memReads - rdBefore, isHit ? 0 : 1);
         end
         testsRun++;
         if (cpu_rdata !== expData) begin
            testsFailed++;
            $display("[TB] FAIL %s rdata: got %h required %h", name, cpu_rdata, expData);
         end
         if (isHit) begin
            expHits = (expHits < 255) ? expHits + 1 : 255;
         end else begin
            expMisses = (expMisses < 255) ? expMisses + 1 : 255;
            modelValid[a[2:0]] = 1'b1;
            modelKey[a[2:0]] = {ins, a};
         end
      end else begin
         testsRun++;
         if (memWrites !== wrBefore + 1 || memReads !== rdBefore) begin
            testsFailed++;
            $display("[TB] FAIL %s write_traffic: got %0d writes %0d reads required 1 write 0 reads", name, memWrites - wrBefore, memReads - rdBefore);
         end
         testsRun++;
         if (lastWrAddr !== a || lastWrData !== wd) begin
            testsFailed++;
            $display("[TB] FAIL %s write_payload: got %h/%h required %h/%h", name, lastWrAddr, lastWrData, a, wd);
         end
      end
      if (checkLat) begin
         expCycles = isHit ? 1 : respLat + 2;
         testsRun++;
         if (cycles != expCycles) begin
            testsFailed++;
            $display("[TB] FAIL %s latency: got %0d required %0d", name, cycles, expCycles);
         end
      end
      if (flushMid) modelInvalidate();
      checkOutput(name);
      cpu_read = 1'b0;
      cpu_write = 1'b0;
      @(negedge clk);
      testsRun++;
      if (cpu_done !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL %s done_pulse: got %b required 0", name, cpu_done);
      end
   endtask

   // Compares both performance counters against the model.
   task automatic checkOutput(input string name);
      testsRun++;
      if (hit_count !== 8'(expHits) || miss_count !== 8'(expMisses)) begin
         testsFailed++;
         $display("[TB] FAIL %s counters: got hit=%0d miss=%0d required hit=%0d miss=%0d", name, hit_count, miss_count, expHits, expMisses);
      end
   endtask

   // Everything must be quiet while reset is held.
   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      testsRun++;
      if ({cpu_done, mem_read, mem_write, mem_instruction} !== 4'b0 || cpu_rdata !== '0 ||
          mem_address !== '0 || mem_dataIn !== '0 || hit_count !== '0 || miss_count !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs: got done=%b rd=%b wr=%b addr=%h rdata=%h hit=%0d miss=%0d required all 0",
                  cpu_done, mem_read, mem_write, mem_address, cpu_rdata, hit_count, miss_count);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Cold read misses and fills; the same read then hits in one cycle.
   task automatic test_cold_read();
      applyStimulus(13'h005, 13'h000, 1, 0, 0, 0, 1, "cold_read");
      testsRun++;
      if (cpu_rdata !== 13'h0F0 || miss_count !== 8'd1) begin
         testsFailed++;
         $display("[TB] FAIL cold_read_value: got rdata=%h miss=%0d required 0f0 and 1", cpu_rdata, miss_count);
      end
      applyStimulus(13'h005, 13'h000, 1, 0, 0, 0, 1, "repeat_read");
      testsRun++;
      if (hit_count !== 8'd1) begin
         testsFailed++;
         $display("[TB] FAIL repeat_read_hits: got %0d required 1", hit_count);
      end
   endtask

   // Write hit updates the line; write miss does not allocate.
   task automatic test_write();
      applyStimulus(13'h005, 13'h0AA, 0, 1, 0, 0, 1, "write_hit");
      applyStimulus(13'h005, 13'h000, 1, 0, 0, 0, 1, "read_after_write");
      testsRun++;
      if (cpu_rdata !== 13'h0AA) begin
         testsFailed++;
         $display("[TB] FAIL write_hit_data: got %h required 0aa", cpu_rdata);
      end
      applyStimulus(13'h00D, 13'h155, 0, 1, 0, 0, 1, "write_miss");
      applyStimulus(13'h00D, 13'h000, 1, 0, 0, 0, 1, "read_after_write_miss");
   endtask

   // Aliasing addresses evict each other; fetch and data never share a hit.
   task automatic test_evict();
      int missBefore;
      missBefore = miss_count;
      applyStimulus(13'h005, 13'h000, 1, 0, 0, 0, 1, "evict_a");
      applyStimulus(13'h00D, 13'h000, 1, 0, 0, 0, 1, "evict_b");
      applyStimulus(13'h005, 13'h000, 1, 0, 0, 0, 1, "evict_a_again");
      testsRun++;
      if (int'(miss_count) != missBefore + 3) begin
         testsFailed++;
         $display("[TB] FAIL evict_three_misses: got %0d required %0d", miss_count, missBefore + 3);
      end
      applyStimulus(13'h005, 13'h000, 1, 0, 1, 0, 1, "ifetch_after_data");
      testsRun++;
      if (lastRdInstr !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL ifetch_flag: got %b required 1", lastRdInstr);
      end
   endtask

   // A flush pulse in IDLE takes effect immediately.
   task automatic test_flush_idle();
      applyStimulus(13'h003, 13'h000, 1, 0, 0, 0, 1, "flush_idle_fill");
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      modelInvalidate();
      applyStimulus(13'h003, 13'h000, 1, 0, 0, 0, 1, "flush_idle_reread");
   endtask

   // A flush raised mid-miss waits for the fill, then wipes the line.
   task automatic test_flush_busy();
      applyStimulus(13'h1A3, 13'h000, 1, 0, 0, 1, 0, "flush_busy_fill");
      applyStimulus(13'h1A3, 13'h000, 1, 0, 0, 0, 0, "flush_busy_reread");
   endtask

   // Reset during a miss kills the memory read and clears everything.
   task automatic test_reset_mid();
      forceLat = 10;
      cpu_addr = 13'h105;
      cpu_wdata = '0;
      cpu_instruction = 1'b0;
      cpu_read = 1'b1;
      @(negedge clk);
      testsRun++;
      if (mem_read !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL reset_mid_pre: got mem_read=%b required 1", mem_read);
      end
      reset = 1'b0;
      #1;
      testsRun++;
      if (mem_read !== 1'b0 || cpu_done !== 1'b0 || mem_write !== 1'b0 || hit_count !== '0 || miss_count !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_mid: got rd=%b done=%b hit=%0d miss=%0d required all 0", mem_read, cpu_done, hit_count, miss_count);
      end
      cpu_read = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      forceLat = -1;
      modelInvalidate();
      expHits = 0;
      expMisses = 0;
      @(negedge clk);
      applyStimulus(13'h105, 13'h000, 1, 0, 0, 0, 1, "reset_mid_reread");
   endtask

   // Read and write together take the write path.
   task automatic test_read_write_together();
      applyStimulus(13'h006, 13'h000, 1, 0, 0, 0, 1, "rw_prefill");
      applyStimulus(13'h006, 13'h123, 1, 1, 0, 0, 1, "rw_together");
      applyStimulus(13'h006, 13'h000, 1, 0, 0, 0, 1, "rw_readback");
      testsRun++;
      if (cpu_rdata !== 13'h123) begin
         testsFailed++;
         $display("[TB] FAIL rw_readback_value: got %h required 123", cpu_rdata);
      end
   endtask

   // Random mix over a small set of aliasing addresses.
   task automatic test_random();
      logic [12:0] upperPool [4];
      logic [12:0] a;
      int          op;
      bit          ins;
      upperPool[0] = 13'h0000;
      upperPool[1] = 13'h0008;
      upperPool[2] = 13'h0A40;
      upperPool[3] = 13'h1FF8;
      for (int i = 0; i < 200; i++) begin
         a = upperPool[$urandom_range(0, 3)] | 13'($urandom_range(0, 7));
         op = $urandom_range(0, 9);
         ins = (op < 6) && ($urandom_range(0, 3) == 0);
         applyStimulus(a, 13'($urandom), (op < 6) || (op == 9), (op >= 6), ins, 0, 1, "random");
      end
   endtask

   // Many hits drive the hit counter into saturation.
   task automatic test_saturate();
      for (int i = 0; i < 300; i++) begin
         applyStimulus(13'h007, 13'h000, 1, 0, 0, 0, 1, "saturate");
      end
      testsRun++;
      if (hit_count !== 8'hFF) begin
         testsFailed++;
         $display("[TB] FAIL hit_saturate: got %0d required 255", hit_count);
      end
   endtask

   initial begin
      cpu_addr = '0;
      cpu_wdata = '0;
      cpu_read = 1'b0;
      cpu_write = 1'b0;
      cpu_instruction = 1'b0;
      flush = 1'b0;
      for (int i = 0; i < 8192; i++) begin
         dmem[i] = 13'($urandom);
         imem[i] = 13'($urandom);
      end
      dmem[5] = 13'h0F0;
      modelInvalidate();
      test_reset();
      test_cold_read();
      test_write();
      test_evict();
      test_flush_idle();
      test_flush_busy();
      test_reset_mid();
      test_read_write_together();
      test_random();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
